// File: rtl/key_sched_ctrl_if.sv
// Key-load handshake and round-key read bus of the AES-128 key-schedule controller.
// The zeroize request exists only when KEY_SCHED_ZEROIZE_EN is defined.
interface key_sched_ctrl_if #(
    parameter int RK_IDX_W = 4
);
    logic                keyValid;
    logic [127:0]        key;
    logic                keyReady;
    logic                busy;
    logic                keysValid;
    logic [RK_IDX_W-1:0] rkIndex;
    logic [127:0]        roundKey;

`ifdef KEY_SCHED_ZEROIZE_EN
    logic                zeroize;

    modport master (
        output keyValid, key, rkIndex, zeroize,
        input  keyReady, busy, keysValid, roundKey
    );

    modport slave (
        input  keyValid, key, rkIndex, zeroize,
        output keyReady, busy, keysValid, roundKey
    );
`else
    modport master (
        output keyValid, key, rkIndex,
        input  keyReady, busy, keysValid, roundKey
    );

    modport slave (
        input  keyValid, key, rkIndex,
        output keyReady, busy, keysValid, roundKey
    );
`endif
endinterface

// File: rtl/key_sched_ctrl.sv
// Iterative AES-128 key expander: one round key per clock into an 11-entry register file.
// Optional macro KEY_SCHED_ZEROIZE_EN adds a zeroize request and a one-entry-per-cycle WIPE state.
module key_sched_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int RK_IDX_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    key_sched_ctrl_if.slave  bus
);

    localparam int NUM_KEYS = NUM_ROUNDS + 1;

    if (NUM_ROUNDS != 10 || RK_IDX_W < 4) begin : g_bad_config
        $error("key_sched_ctrl supports only NUM_ROUNDS=10 with RK_IDX_W>=4");
    end

`ifdef KEY_SCHED_ZEROIZE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2, WIPE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;
`endif

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t       state;
    state_t       nextState;
    logic [3:0]   roundCtr;
    logic [3:0]   prevIdx;
    logic         lastRound;
    logic         keysValidQ;
    logic         readyInt;
    logic         wipeReq;
    logic [7:0]   rcon;
    logic [127:0] prevKey;
    logic [31:0]  rotWord;
    logic [31:0]  subWord;
    logic [31:0]  w0, w1, w2, w3;
    logic [127:0] nextKey;
    logic [127:0] rk [NUM_KEYS];

`ifdef KEY_SCHED_ZEROIZE_EN
    assign wipeReq = bus.zeroize;
`else
    assign wipeReq = 1'b0;
`endif

    assign lastRound = (roundCtr == 4'(NUM_ROUNDS));
    assign prevIdx   = (roundCtr == 4'd0) ? 4'd0 : roundCtr - 4'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: if (bus.keyValid) nextState = EXPAND;
            EXPAND:     if (lastRound)    nextState = DONE;
`ifdef KEY_SCHED_ZEROIZE_EN
            WIPE:       if (lastRound)    nextState = IDLE;
`endif
            default:                      nextState = IDLE;
        endcase
`ifdef KEY_SCHED_ZEROIZE_EN
        if (wipeReq) nextState = WIPE;
`endif
    end

    always_comb begin
        readyInt      = (state == IDLE) || (state == DONE);
        bus.keyReady  = readyInt;
`ifdef KEY_SCHED_ZEROIZE_EN
        bus.busy      = (state == EXPAND) || (state == WIPE);
`else
        bus.busy      = (state == EXPAND);
`endif
        bus.keysValid = keysValidQ;
    end

    // Single shared S-box set: the round counter walks one word transform through all rounds.
    always_comb begin
        case (roundCtr)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        prevKey = rk[prevIdx];
        rotWord = {prevKey[23:0], prevKey[31:24]};
        subWord = {SBOX[rotWord[31:24]], SBOX[rotWord[23:16]], SBOX[rotWord[15:8]], SBOX[rotWord[7:0]]};
        w0      = prevKey[127:96] ^ subWord ^ {rcon, 24'h0};
        w1      = prevKey[95:64] ^ w0;
        w2      = prevKey[63:32] ^ w1;
        w3      = prevKey[31:0]  ^ w2;
        nextKey = {w0, w1, w2, w3};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            roundCtr   <= 4'd0;
            keysValidQ <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) rk[i] <= '0;
        end else if (wipeReq) begin
            roundCtr   <= 4'd0;
            keysValidQ <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.keyValid) begin
                        rk[0]      <= bus.key;
                        roundCtr   <= 4'd1;
                        keysValidQ <= 1'b0;
                    end
                end
                EXPAND: begin
                    rk[roundCtr] <= nextKey;
                    if (lastRound) begin
                        roundCtr   <= 4'd0;
                        keysValidQ <= 1'b1;
                    end else begin
                        roundCtr   <= roundCtr + 4'd1;
                    end
                end
`ifdef KEY_SCHED_ZEROIZE_EN
                WIPE: begin
                    rk[roundCtr] <= '0;
                    roundCtr     <= lastRound ? 4'd0 : roundCtr + 4'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Out-of-range indices read as zero rather than aliasing a stored key.
    always_comb begin
        bus.roundKey = '0;
        if (int'(bus.rkIndex) <= NUM_ROUNDS) bus.roundKey = rk[bus.rkIndex];
    end

    assert property (@(posedge clock) disable iff (reset) (bus.keyValid && readyInt) |-> !$isunknown(bus.key));
    assert property (@(posedge clock) roundCtr <= 4'(NUM_ROUNDS));
    assert property (@(posedge clock) disable iff (reset) keysValidQ |-> (state == DONE));

endmodule

// File: doc/key_sched_ctrl.md
Name: key_sched_ctrl

Overview:
Sequential AES-128 key-schedule controller. It accepts a cipher key through a valid/ready handshake and expands it iteratively, producing one 128-bit round key per clock. The round keys are held in an internal register file. A random-access read port serves the round pipeline/cipher controller. This is the area-reduced alternative to the fully combinational all-rounds expander, and it sits between the key-load interface and the cipher datapath.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds; NUM_ROUNDS+1 round keys are stored (only 10 is supported; other values are a lint/elab error)
RK_IDX_W, 4, width of the round-key read index

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
keyValid  input  1  key load request
key  input  128  cipher key, byte 0 in bits [127:120]
keyReady  output  1  controller can accept a key this cycle
busy  output  1  expansion in progress
keysValid  output  1  all NUM_ROUNDS+1 round keys are stored and coherent
rkIndex  input  RK_IDX_W  round-key read select
roundKey  output  128  round key selected by rkIndex (combinational read)
zeroize  input  1  present only with KEY_SCHED_ZEROIZE_EN

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- State machine: IDLE, EXPAND, DONE (plus WIPE, only with the optional feature).
- Reset values: state=IDLE, roundCtr=0, keysValid=0, busy=0, every storage entry=0. keyReady=1 in the cycle after reset deasserts.
- keyReady = (state==IDLE || state==DONE). busy = (state==EXPAND).
- Accept occurs when keyValid && keyReady at edge T:
  - rk[0] <= key; roundCtr <= 1; keysValid <= 0; state <= EXPAND.
- EXPAND: at each edge, rk[roundCtr] <= next(rk[roundCtr-1], RCON[roundCtr]); roundCtr++.
  - next(): w0' = w0 ^ SubWord(RotWord(w3)) ^ {RCON,24'h0}; wi' = wi-1' ^ wi for i=1..3.
  - RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Completion: the edge that writes rk[NUM_ROUNDS] (edge T+NUM_ROUNDS) also sets keysValid=1 and state=DONE. Total latency from accept edge to keysValid high is NUM_ROUNDS cycles.
- Key presented while busy: keyValid is ignored (keyReady=0). The source must hold keyValid and key until it is accepted.
- New key accepted in DONE: keysValid drops at the accept edge, then re-expansion runs. Consumers must stall on keysValid.
- Read port: roundKey = rk[rkIndex] for rkIndex <= NUM_ROUNDS, else 128'h0.
  - Reads are legal in any state. Entries not yet rewritten during EXPAND hold the previous key's schedule.
- Reset mid-EXPAND: returns to IDLE, clears storage, keysValid=0. No partial completion.
- keyValid asserted together with reset: reset wins and the key is not accepted.
- Exactly one S-box set (4 byte lookups) is instantiated; it is shared across rounds by iteration.
- Assertions:
  - key is known when keyValid && keyReady.
  - roundCtr <= NUM_ROUNDS.
  - keysValid implies state==DONE.

Optional Feature:
KEY_SCHED_ZEROIZE_EN
- With the macro defined:
  - The zeroize port exists.
  - zeroize=1 in any state moves the block to WIPE at the next edge, clears keysValid, and aborts any expansion.
  - WIPE clears one storage entry per cycle, index 0..NUM_ROUNDS (NUM_ROUNDS+1 cycles), then returns to IDLE.
  - keyReady=0 and busy=1 during WIPE.
  - zeroize outranks a simultaneous key accept. Reset outranks zeroize.
- Without the macro: no port and no WIPE state. Storage is cleared only by reset or overwritten by a new key.

Test Plan:
- Reset, then idle: keyReady=1, keysValid=0, busy=0, roundKey=0 for all indices 0..15.
- Load FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c at edge T:
  - busy=1 during edges T+1..T+10; keysValid=1 after edge T+10.
  - rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6; rkIndex=11 reads 0.
- keyValid held with key 000102030405060708090a0b0c0d0e0f during EXPAND: not accepted until DONE (keyReady=0). It is then accepted, and rk[10] = 13111d7fe3944a17f307a78b4d2b30c5.
- Reset asserted at edge T+4 of an expansion: next cycle state=IDLE, keysValid=0, all rk=0. A fresh load then completes normally.
- Back-to-back loads, accepted in DONE and again in the following DONE: keysValid low for exactly 10 cycles each time, and the second schedule is correct.
- (KEY_SCHED_ZEROIZE_EN) zeroize pulse in DONE:
  - keysValid=0 next cycle; keyReady=0 for 11 cycles; then IDLE with all rk=0.
  - zeroize during EXPAND aborts the expansion, with the same response.
